// File: rtl/conva_multi_accum_dp.sv
// conva_multi_accum_dp: sums NUMBER_OF_UNITS lanes per OFM pixel over PASSES passes, adds the filter bias, applies ReLU and streams pixels.
// Latency: an accepted last-pass beat shows on out_valid one cycle later, so full throughput is one pixel per cycle.
// Backpressure: on the last pass unit_ready drops while a stalled pixel is held. Define CONVA_MULTI_ACCUM_SATURATE_EN for saturating adds plus sat_flag.
module conva_multi_accum_dp #(
    parameter int DATA_WIDTH         = 32,
    parameter int ADDRESS_BITS       = 17,
    parameter int OFM_SIZE           = 30,
    parameter int IFM_DEPTH          = 6,
    parameter int NUMBER_OF_UNITS    = 3,
    parameter int NUMBER_OF_FILTERS  = 8,
    parameter int RELU_ENABLE        = 1,
    localparam int FILTER_BITS       = (NUMBER_OF_FILTERS > 1) ? $clog2(NUMBER_OF_FILTERS) : 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [DATA_WIDTH-1:0]                 riscv_data,
    input  logic [ADDRESS_BITS-1:0]               riscv_address,
    input  logic                                  bm_enable_write,
    input  logic                                  start,
    input  logic [FILTER_BITS-1:0]                filter_index,
    input  logic                                  unit_valid,
    output logic                                  unit_ready,
    input  logic [NUMBER_OF_UNITS*DATA_WIDTH-1:0] unit_data_in,
    output logic [DATA_WIDTH-1:0]                 data_out_for_next,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  busy,
`ifdef CONVA_MULTI_ACCUM_SATURATE_EN
    output logic                                  sat_flag,
`endif
    output logic                                  done
);

    localparam int PASSES    = (IFM_DEPTH + NUMBER_OF_UNITS - 1) / NUMBER_OF_UNITS;
    localparam int NPIX      = OFM_SIZE * OFM_SIZE;
    localparam int PIX_BITS  = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int PASS_BITS = (PASSES > 1) ? $clog2(PASSES) : 1;
`ifdef CONVA_MULTI_ACCUM_SATURATE_EN
    localparam logic [DATA_WIDTH-1:0] SMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif

    // Returns {clipped, sum}; clipped can only be set in the saturating build.
    function automatic logic [DATA_WIDTH:0] add_w(input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH-1:0] s;
        s = a + b;
`ifdef CONVA_MULTI_ACCUM_SATURATE_EN
        if ((a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) && (s[DATA_WIDTH-1] != a[DATA_WIDTH-1]))
            return {1'b1, a[DATA_WIDTH-1] ? SMIN : SMAX};
`endif
        return {1'b0, s};
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ACCUM, S_DRAIN} state_t;
    state_t state;

    logic [DATA_WIDTH-1:0]  bias_mem [NUMBER_OF_FILTERS];
    logic [DATA_WIDTH-1:0]  psum_buf [NPIX];
    logic [DATA_WIDTH-1:0]  bias_reg;
    logic [FILTER_BITS-1:0] filter_sel;
    logic [PIX_BITS-1:0]    pix_cnt;
    logic [PASS_BITS-1:0]   pass_cnt;

    logic                   last_pass;
    logic                   last_pix;
    logic                   out_hs;
    logic                   beat;
    logic [DATA_WIDTH-1:0]  lane_sum;
    logic [DATA_WIDTH:0]    lane_r;
    logic                   lane_clip;
    logic [DATA_WIDTH-1:0]  psum_rd;
    logic [DATA_WIDTH:0]    acc_r;
    logic [DATA_WIDTH:0]    fin_r;
    logic [DATA_WIDTH-1:0]  result;
    logic                   clip_any;

    assign last_pass  = (pass_cnt == PASS_BITS'(PASSES - 1));
    assign last_pix   = (pix_cnt == PIX_BITS'(NPIX - 1));
    assign out_hs     = out_valid && out_ready;
    assign unit_ready = (state == S_ACCUM) && !(last_pass && out_valid && !out_ready);
    assign beat       = unit_valid && unit_ready;

    // Lanes past IFM_DEPTH on the current pass carry no channel and are dropped.
    always_comb begin
        lane_sum  = '0;
        lane_clip = 1'b0;
        lane_r    = '0;
        for (int k = 0; k < NUMBER_OF_UNITS; k++) begin
            if (int'(pass_cnt) * NUMBER_OF_UNITS + k < IFM_DEPTH) begin
                lane_r    = add_w(lane_sum, unit_data_in[k*DATA_WIDTH +: DATA_WIDTH]);
                lane_sum  = lane_r[DATA_WIDTH-1:0];
                lane_clip = lane_clip | lane_r[DATA_WIDTH];
            end
        end
    end

    // Pass 0 starts from zero, so stale buffer contents never leak into a new filter.
    assign psum_rd  = (pass_cnt == '0) ? '0 : psum_buf[pix_cnt];
    assign acc_r    = add_w(psum_rd, lane_sum);
    assign fin_r    = add_w(acc_r[DATA_WIDTH-1:0], bias_reg);
    assign result   = ((RELU_ENABLE != 0) && fin_r[DATA_WIDTH-1]) ? '0 : fin_r[DATA_WIDTH-1:0];
    assign clip_any = lane_clip | acc_r[DATA_WIDTH] | (last_pass & fin_r[DATA_WIDTH]);

    always_ff @(posedge clk) begin
        if (bm_enable_write)
            bias_mem[riscv_address[FILTER_BITS-1:0]] <= riscv_data;
    end

    always_ff @(posedge clk) begin
        if (beat && !last_pass)
            psum_buf[pix_cnt] <= acc_r[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= S_IDLE;
            busy              <= 1'b0;
            done              <= 1'b0;
            out_valid         <= 1'b0;
            data_out_for_next <= '0;
            bias_reg          <= '0;
            filter_sel        <= '0;
            pix_cnt           <= '0;
            pass_cnt          <= '0;
        end else begin
            done <= 1'b0;
            // A new last-pass result replaces the one leaving on this edge.
            if (beat && last_pass) begin
                out_valid         <= 1'b1;
                data_out_for_next <= result;
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_LOAD;
                        busy       <= 1'b1;
                        filter_sel <= filter_index;
                    end
                end
                S_LOAD: begin
                    bias_reg <= bias_mem[filter_sel];
                    pix_cnt  <= '0;
                    pass_cnt <= '0;
                    state    <= S_ACCUM;
                end
                S_ACCUM: begin
                    if (beat) begin
                        if (last_pix) begin
                            pix_cnt <= '0;
                            if (last_pass)
                                state <= S_DRAIN;
                            else
                                pass_cnt <= pass_cnt + PASS_BITS'(1);
                        end else begin
                            pix_cnt <= pix_cnt + PIX_BITS'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (out_hs) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CONVA_MULTI_ACCUM_SATURATE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            sat_flag <= 1'b0;
        else if (state == S_IDLE && start)
            sat_flag <= 1'b0;
        else if (beat && clip_any)
            sat_flag <= 1'b1;
    end
`else
    logic unused_clip;
    assign unused_clip = clip_any;
`endif

    // Only the low address bits select a bias entry.
    logic unused_addr;
    assign unused_addr = ^riscv_address;

endmodule

// File: tb/tb_conva_multi_accum_dp.sv
// Bench for conva_multi_accum_dp: random and directed filters against a queue-based model; a ReLU and a pass-through instance share stimulus.
module tb_conva_multi_accum_dp;
    localparam int DW     = 32;
    localparam int AB     = 17;
    localparam int OFM    = 2;
    localparam int DEPTH  = 5;
    localparam int NU     = 3;
    localparam int NF     = 8;
    localparam int FB     = 3;
    localparam int PASSES = (DEPTH + NU - 1) / NU;
    localparam int NPIX   = OFM * OFM;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [DW-1:0]    riscv_data = '0;
    logic [AB-1:0]    riscv_address = '0;
    logic             bm_enable_write = 1'b0;
    logic             start = 1'b0;
    logic [FB-1:0]    filter_index = '0;
    logic             unit_valid = 1'b0;
    logic [NU*DW-1:0] unit_data_in = '0;
    logic             out_ready = 1'b0;

    logic             unit_ready, out_valid, busy, done;
    logic [DW-1:0]    data_out;
    logic             unit_ready_b, out_valid_b, busy_b, done_b;
    logic [DW-1:0]    data_b;
`ifdef CONVA_MULTI_ACCUM_SATURATE_EN
    logic             sat_flag, sat_flag_b;
`endif

    always #5 clk = ~clk;

    conva_multi_accum_dp #(.DATA_WIDTH(DW), .ADDRESS_BITS(AB), .OFM_SIZE(OFM), .IFM_DEPTH(DEPTH),
                           .NUMBER_OF_UNITS(NU), .NUMBER_OF_FILTERS(NF), .RELU_ENABLE(1)) u_dut (
        .clk(clk), .reset(reset), .riscv_data(riscv_data), .riscv_address(riscv_address),
        .bm_enable_write(bm_enable_write), .start(start), .filter_index(filter_index),
        .unit_valid(unit_valid), .unit_ready(unit_ready), .unit_data_in(unit_data_in),
        .data_out_for_next(data_out), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
`ifdef CONVA_MULTI_ACCUM_SATURATE_EN
        .sat_flag(sat_flag),
`endif
        .done(done)
    );

    conva_multi_accum_dp #(.DATA_WIDTH(DW), .ADDRESS_BITS(AB), .OFM_SIZE(OFM), .IFM_DEPTH(DEPTH),
                           .NUMBER_OF_UNITS(NU), .NUMBER_OF_FILTERS(NF), .RELU_ENABLE(0)) u_dut_norelu (
        .clk(clk), .reset(reset), .riscv_data(riscv_data), .riscv_address(riscv_address),
        .bm_enable_write(bm_enable_write), .start(start), .filter_index(filter_index),
        .unit_valid(unit_valid), .unit_ready(unit_ready_b), .unit_data_in(unit_data_in),
        .data_out_for_next(data_b), .out_valid(out_valid_b), .out_ready(out_ready), .busy(busy_b),
`ifdef CONVA_MULTI_ACCUM_SATURATE_EN
        .sat_flag(sat_flag_b),
`endif
        .done(done_b)
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    logic [DW-1:0]    bias_m [NF];
    logic [NU*DW-1:0] beat_q [$];
    logic [DW-1:0]    exp_q [$];
    logic [DW-1:0]    exp_raw_q [$];
    logic [DW-1:0]    obs_q [$];
    logic [DW-1:0]    obs_raw_q [$];
    bit               exp_sat;

    int ready_mode = 1;
    int stall_left = 0;
    int stall_seen = 0;
    int n_out      = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // Signed add: wraps by default, clips to the 32-bit signed range in the saturating build.
    function automatic logic [32:0] madd(input logic [31:0] a, input logic [31:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
`ifdef CONVA_MULTI_ACCUM_SATURATE_EN
        if (s > 64'sd2147483647)  return {1'b1, 32'h7FFF_FFFF};
        if (s < -64'sd2147483648) return {1'b1, 32'h8000_0000};
`endif
        return {1'b0, s[31:0]};
    endfunction

    // mode 0 random, 1 = all-ones then 2/2/100, 2 = near-overflow pattern.
    task automatic plan(input int mode, input logic [31:0] bias);
        logic [31:0]    acc [NPIX];
        logic [31:0]    ls, lane, fin;
        logic [32:0]    r;
        logic [NU*DW-1:0] bt;
        beat_q.delete(); exp_q.delete(); exp_raw_q.delete();
        exp_sat = 1'b0;
        for (int p = 0; p < PASSES; p++) begin
            for (int x = 0; x < NPIX; x++) begin
                ls = '0;
                for (int k = 0; k < NU; k++) begin
                    if (mode == 0)      lane = $urandom;
                    else if (mode == 1) lane = (p == 0) ? 32'd1 : ((k == 2) ? 32'd100 : 32'd2);
                    else                lane = (p != 0) ? 32'd0 : ((k == 0) ? 32'h7FFF_FFF0 : ((k == 1) ? 32'h20 : 32'd0));
                    bt[k*DW +: DW] = lane;
                    if (p * NU + k < DEPTH) begin
                        r = madd(ls, lane);
                        ls = r[31:0];
                        if (r[32]) exp_sat = 1'b1;
                    end
                end
                if (p == 0) acc[x] = ls;
                else begin
                    r = madd(acc[x], ls);
                    acc[x] = r[31:0];
                    if (r[32]) exp_sat = 1'b1;
                end
                beat_q.push_back(bt);
            end
        end
        for (int x = 0; x < NPIX; x++) begin
            r = madd(acc[x], bias);
            if (r[32]) exp_sat = 1'b1;
            fin = r[31:0];
            exp_raw_q.push_back(fin);
            exp_q.push_back(fin[31] ? 32'd0 : fin);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = ($urandom_range(0, 3) != 0);
            1: out_ready = 1'b1;
            default: begin
                if (out_valid && n_out == 1 && stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                end else begin
                    out_ready = 1'b1;
                end
            end
        endcase
    end

    logic [DW-1:0] prev_dat, e, er;
    bit            prev_stall = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", data_out, prev_dat);
            end
            if (out_valid && !out_ready) begin
                stall_seen++;
                check("unit_ready_blocked", unit_ready, 0);
                check("unit_ready_blocked_b", unit_ready_b, 0);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL unexpected_output: got pixel 0x%08h, required no pending pixel", data_out);
                end else begin
                    e  = exp_q.pop_front();
                    er = exp_raw_q.pop_front();
                    check("pixel_relu", data_out, e);
                    check("valid_norelu", out_valid_b, 1);
                    check("pixel_norelu", data_b, er);
                    obs_q.push_back(data_out);
                    obs_raw_q.push_back(data_b);
                    n_out++;
                end
            end
            if (done) begin
                check("done_all_pixels_out", exp_q.size(), 0);
                check("done_busy_low", busy, 0);
                check("done_norelu", done_b, 1);
            end
            prev_stall = out_valid && !out_ready;
            prev_dat   = data_out;
        end
    end

    task automatic write_bias(input logic [FB-1:0] idx, input logic [31:0] val);
        @(posedge clk); #1;
        bm_enable_write = 1'b1;
        riscv_address   = AB'($urandom);
        riscv_address[FB-1:0] = idx;
        riscv_data      = val;
        @(posedge clk); #1;
        bm_enable_write = 1'b0;
        bias_m[idx]     = val;
    endtask

    task automatic feed(input int nbeats, input bit gaps);
        int n;
        for (int i = 0; i < nbeats && beat_q.size() > 0; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                unit_valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            unit_valid   = 1'b1;
            unit_data_in = beat_q.pop_front();
            n = 0;
            do begin @(negedge clk); n++; end while (!unit_ready && n < 200);
            if (!unit_ready) begin
                checks++; fails++;
                $display("FAIL feed_timeout: unit_ready=0 for %0d cycles, required 1", n);
                break;
            end
            @(posedge clk); #1;
        end
        unit_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic [FB-1:0] idx);
        @(posedge clk); #1;
        filter_index = idx;
        start        = 1'b1;
    endtask

    task automatic run_filter(input logic [FB-1:0] idx, input int mode, input bit gaps,
                              input bit inject, output int lat);
        int t0, n;
        logic [31:0] nb;
        plan(mode, bias_m[idx]);
        n_out = 0; stall_seen = 0;
        obs_q.delete(); obs_raw_q.delete();
        pulse_start(idx);
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        filter_index = FB'($urandom);
        check("busy_after_start", busy, 1);
        fork
            feed(PASSES * NPIX, gaps);
            if (inject) begin
                repeat (4) @(posedge clk);
                #1;
                nb = $urandom;
                start = 1'b1;
                filter_index = idx + FB'(1);
                bm_enable_write = 1'b1;
                riscv_address = AB'($urandom);
                riscv_address[FB-1:0] = idx;
                riscv_data = nb;
                @(posedge clk); #1;
                start = 1'b0;
                bm_enable_write = 1'b0;
                bias_m[idx] = nb;
            end
        join
        n = 0;
        do begin @(negedge clk); n++; end while (!done && n < 300);
        if (!done) begin
            checks++; fails++;
            $display("FAIL done_timeout: done=0 after %0d cycles, required 1", n);
        end
        lat = cyc - t0;
        check("outputs_count", n_out, NPIX);
`ifdef CONVA_MULTI_ACCUM_SATURATE_EN
        check("sat_flag", sat_flag, exp_sat);
        check("sat_flag_norelu", sat_flag_b, exp_sat);
`endif
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, required test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_unit_ready", unit_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_data_out", data_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
`ifdef CONVA_MULTI_ACCUM_SATURATE_EN
        check("rst_sat_flag", sat_flag, 0);
`endif
        #2 reset = 1'b1;

        // Directed: 3 + 4 + 10 = 17 per pixel, full throughput.
        ready_mode = 1;
        write_bias(3, 32'd10);
        run_filter(3, 1, 1'b0, 1'b0, lat);
        check("full_rate_start_to_done", lat, 11);
        for (int i = 0; i < obs_q.size(); i++) begin
            check("lit_relu_17", obs_q[i], 32'd17);
            check("lit_raw_17", obs_raw_q[i], 32'd17);
        end

        // Directed: 7 - 50 = -43, clipped to 0 by ReLU.
        write_bias(3, 32'hFFFF_FFCE);
        run_filter(3, 1, 1'b0, 1'b0, lat);
        for (int i = 0; i < obs_q.size(); i++) begin
            check("lit_relu_neg", obs_q[i], 32'd0);
            check("lit_raw_neg", obs_raw_q[i], 32'hFFFF_FFD5);
        end

        // Five-cycle output stall on the second pixel of the last pass.
        ready_mode = 2;
        stall_left = 5;
        run_filter(3, 0, 1'b0, 1'b0, lat);
        check("stall_cycles", stall_seen, 5);

        // Reset during pass 1, pixel 2.
        ready_mode = 1;
        plan(0, bias_m[3]);
        n_out = 0;
        pulse_start(3);
        @(posedge clk); #1;
        start = 1'b0;
        feed(NPIX + 2, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_data_out", data_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_unit_ready", unit_ready, 0);
        check("midrst_done", done, 0);
        beat_q.delete(); exp_q.delete(); exp_raw_q.delete();
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        ready_mode = 0;
        run_filter(3, 0, 1'b1, 1'b0, lat);

        // Extra start and bias rewrite while busy: old bias for this filter, new for the next.
        write_bias(5, $urandom);
        run_filter(5, 0, 1'b1, 1'b1, lat);
        @(negedge clk);
        check("extra_start_ignored", busy, 0);
        run_filter(5, 0, 1'b1, 1'b0, lat);

        for (int t = 0; t < 6; t++) begin
            logic [FB-1:0] idx;
            idx = FB'($urandom);
            write_bias(idx, $urandom);
            run_filter(idx, 0, 1'b1, 1'b0, lat);
        end

        // Near-overflow pair of lanes with zero bias.
        ready_mode = 1;
        write_bias(0, 32'd0);
        run_filter(0, 2, 1'b0, 1'b0, lat);
        for (int i = 0; i < obs_q.size(); i++) begin
`ifdef CONVA_MULTI_ACCUM_SATURATE_EN
            check("lit_sat_relu", obs_q[i], 32'h7FFF_FFFF);
            check("lit_sat_raw", obs_raw_q[i], 32'h7FFF_FFFF);
`else
            check("lit_wrap_relu", obs_q[i], 32'd0);
            check("lit_wrap_raw", obs_raw_q[i], 32'h8000_0010);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
